intra_score_gen: RTL



---
 rtl/intra_score_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/intra_score_gen.sv
// intra_score_gen: turns a stream of signed residual samples (NUM_SAMPLES per
// candidate mode, modes 0..9 in order) into ten parallel rate-distortion
// scores: score[m] = (SSE_m << SSE_SHIFT) + lambda * rate_m.
// Optional feature macro: INTRA_SCORE_MODE_MASK_EN adds a per-block mode mask;
// masked-off modes report the maximum positive score.
module intra_score_gen #(
  parameter int SSE_SHIFT   = 8,
  parameter int NUM_SAMPLES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] lambda,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_diff,
  input  logic [15:0] in_rate,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef INTRA_SCORE_MODE_MASK_EN
  input  logic [9:0]  mode_mask,
`endif
  output logic [63:0] score0,
  output logic [63:0] score1,
  output logic [63:0] score2,
  output logic [63:0] score3,
  output logic [63:0] score4,
  output logic [63:0] score5,
  output logic [63:0] score6,
  output logic [63:0] score7,
  output logic [63:0] score8,
  output logic [63:0] score9
);

  localparam int          NUM_MODES = 10;
  localparam logic [3:0]  LAST_BEAT = 4'(NUM_SAMPLES - 1);
  localparam logic [3:0]  LAST_MODE = 4'(NUM_MODES - 1);
  localparam logic [63:0] SCORE_MAX = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [20:0] sse_q;
  logic [3:0]  beat_cnt_q;
  logic [3:0]  mode_cnt_q;
  logic [15:0] lambda_q;
  logic [63:0] score_q [NUM_MODES];
`ifdef INTRA_SCORE_MODE_MASK_EN
  logic [9:0]  mask_q;
`endif

  logic               start_fire;
  logic               beat_fire;
  logic               last_beat;
  logic               last_mode;
  logic signed [8:0]  diff_s;
  logic signed [17:0] sq_s;
  logic [20:0]        sse_sum;
  logic [31:0]        rate_term;
  logic [63:0]        score_calc;

  // Handshake qualifiers are decoded from the state register, not from the
  // in_ready output, so the FSM next-state logic has no feedback through it.
  assign start_fire = (state_q == ST_IDLE) && start;
  assign beat_fire  = (state_q == ST_ACC) && in_valid;
  assign last_beat  = beat_fire && (beat_cnt_q == LAST_BEAT);
  assign last_mode  = (mode_cnt_q == LAST_MODE);

  // Square of a 9-bit signed sample is at most 65536, so the 18-bit signed
  // product is never negative and zero-extends safely into the 21-bit SSE.
  assign diff_s     = in_diff;
  assign sq_s       = diff_s * diff_s;
  assign sse_sum    = sse_q + {3'b000, sq_s};
  assign rate_term  = lambda_q * in_rate;
  assign score_calc = ({43'd0, sse_sum} << SSE_SHIFT) + {32'd0, rate_term};

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACC;
      end
      ST_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_beat && last_mode) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-block parameters and accumulation counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sse_q      <= '0;
      beat_cnt_q <= '0;
      mode_cnt_q <= '0;
      lambda_q   <= '0;
`ifdef INTRA_SCORE_MODE_MASK_EN
      mask_q     <= '0;
`endif
    end else if (start_fire) begin
      sse_q      <= '0;
      beat_cnt_q <= '0;
      mode_cnt_q <= '0;
      lambda_q   <= lambda;
`ifdef INTRA_SCORE_MODE_MASK_EN
      mask_q     <= mode_mask;
`endif
    end else if (beat_fire) begin
      if (last_beat) begin
        sse_q      <= '0;
        beat_cnt_q <= '0;
        mode_cnt_q <= last_mode ? 4'd0 : mode_cnt_q + 4'd1;
      end else begin
        sse_q      <= sse_sum;
        beat_cnt_q <= beat_cnt_q + 4'd1;
      end
    end
  end

  // Score bank: the current mode's slot is written on its last beat and held
  // otherwise, so scores stay stable through DONE and across blocks.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the score bank is a register array with a visible reset value,
    // so it is reset explicitly; it cannot be mapped to a RAM macro.
    if (!rstn) begin
      for (int m = 0; m < NUM_MODES; m++) score_q[m] <= '0;
    end else if (last_beat) begin
      for (int m = 0; m < NUM_MODES; m++) begin
        if (mode_cnt_q == 4'(m)) begin
`ifdef INTRA_SCORE_MODE_MASK_EN
          score_q[m] <= mask_q[m] ? score_calc : SCORE_MAX;
`else
          score_q[m] <= score_calc;
`endif
        end
      end
    end
  end

  assign score0 = score_q[0];
  assign score1 = score_q[1];
  assign score2 = score_q[2];
  assign score3 = score_q[3];
  assign score4 = score_q[4];
  assign score5 = score_q[5];
  assign score6 = score_q[6];
  assign score7 = score_q[7];
  assign score8 = score_q[8];
  assign score9 = score_q[9];

endmodule
